// File: rtl/config_serial_tx.sv
// config_serial_tx
// Shifts a WIDTH-bit configuration word out LSB-first over the three-wire
// sen/sclk/sdata link. Afterwards it drops sen, which the receiver decodes as
// start-of-render. A short gap with busy held high follows each frame.
// Every output comes straight from a register, so the receiver's synchronizers
// never see combinational glitches.
module config_serial_tx #(
  parameter int WIDTH       = 52,
  parameter int HALF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             sen,
  output logic             sclk,
  output logic             sdata
);

  // A single-cycle sclk phase would let the receiver's 3-flop synchronizer miss
  // a level, so such a configuration is refused at elaboration time.
  if (HALF_PERIOD < 2) begin : g_bad_half_period
    $error("config_serial_tx: HALF_PERIOD must be >= 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("config_serial_tx: WIDTH must be >= 1");
  end

  localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int BC_W = $clog2(WIDTH + 1);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOW   = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_TRAIL = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic [PH_W-1:0]  ph_reg, ph_next;
  logic [BC_W-1:0]  bc_reg, bc_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             sen_reg, sen_next;
  logic             sclk_reg, sclk_next;
  logic             sdata_reg, sdata_next;

  logic             phase_end;
  logic [WIDTH-1:0] sr_shift;

  // The phase counter marks the last cycle of every sclk half period.
  assign phase_end = (ph_reg == PH_LAST);
  // The shift register moves right, so its LSB is always the next bit to send.
  assign sr_shift  = sr_reg >> 1;

  // Next-state and next-output logic. Outputs are computed one cycle ahead so
  // that they appear together with the matching state.
  always_comb begin
    state_next = state_reg;
    ph_next    = ph_reg;
    bc_next    = bc_reg;
    sr_next    = sr_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    sen_next   = sen_reg;
    sclk_next  = sclk_reg;
    sdata_next = sdata_reg;

    case (state_reg)
      ST_IDLE: begin
        // The word is captured only here. Later changes on data, and starts
        // that arrive while busy, have no effect.
        if (start) begin
          state_next = ST_LOW;
          sr_next    = data;
          bc_next    = '0;
          ph_next    = '0;
          busy_next  = 1'b1;
          sen_next   = 1'b1;
          sclk_next  = 1'b0;
          sdata_next = data[0];
        end
      end

      ST_LOW: begin
        if (phase_end) begin
          ph_next    = '0;
          state_next = ST_HIGH;
          sclk_next  = 1'b1;
        end else begin
          ph_next = ph_reg + PH_ONE;
        end
      end

      ST_HIGH: begin
        // sdata stays untouched for the whole high phase. It changes only
        // together with sclk falling, when LOW is entered again.
        if (phase_end) begin
          ph_next   = '0;
          sr_next   = sr_shift;
          bc_next   = bc_reg + BC_ONE;
          sclk_next = 1'b0;
          if (bc_reg == BC_LAST) begin
            state_next = ST_TRAIL;
            sdata_next = 1'b0;
          end else begin
            state_next = ST_LOW;
            sdata_next = sr_shift[0];
          end
        end else begin
          ph_next = ph_reg + PH_ONE;
        end
      end

      ST_TRAIL: begin
        // The falling edge of sen is the receiver's start-of-render, and
        // done marks that same cycle.
        if (phase_end) begin
          ph_next    = '0;
          state_next = ST_GAP;
          sen_next   = 1'b0;
          done_next  = 1'b1;
        end else begin
          ph_next = ph_reg + PH_ONE;
        end
      end

      ST_GAP: begin
        if (phase_end) begin
          ph_next    = '0;
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end else begin
          ph_next = ph_reg + PH_ONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        ph_next    = '0;
        bc_next    = '0;
        busy_next  = 1'b0;
        sen_next   = 1'b0;
        sclk_next  = 1'b0;
        sdata_next = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset wins over a simultaneous start and
  // discards any frame that is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ph_reg    <= '0;
      bc_reg    <= '0;
      sr_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      sen_reg   <= 1'b0;
      sclk_reg  <= 1'b0;
      sdata_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ph_reg    <= ph_next;
      bc_reg    <= bc_next;
      sr_reg    <= sr_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      sen_reg   <= sen_next;
      sclk_reg  <= sclk_next;
      sdata_reg <= sdata_next;
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign sen   = sen_reg;
  assign sclk  = sclk_reg;
  assign sdata = sdata_reg;

endmodule

// File: tb/tb_config_serial_tx.sv
// tb_config_serial_tx
// Drives several config_serial_tx instances with different WIDTH/HALF_PERIOD
// settings. Each instance has its own receiver model (3-flop synchronizer,
// shift on synchronized rising sclk while sen is high). Expected words go into
// a queue when a start is accepted. They are popped and compared once the
// frame has finished.
`timescale 1ns/1ps
module tb_config_serial_tx;

  localparam int NI = 4;
  localparam logic [63:0] MASK52 = (64'd1 << 52) - 64'd1;

  function automatic int w_of(input int i);
    return (i < 2) ? 52 : 8;
  endfunction

  function automatic int h_of(input int i);
    case (i)
      0:       return 4;
      1:       return 2;
      2:       return 7;
      default: return 2;
    endcase
  endfunction

  logic clk = 1'b0;
  logic reset;
  logic [NI-1:0] start_v;
  logic [NI-1:0] mon_clr;
  logic [63:0]   data_a [NI];
  logic [NI-1:0] busy_v, done_v, sen_v, sclk_v, sdata_v;
  logic [NI-1:0][63:0] rx_p;
  logic [NI-1:0][15:0] rises_p, senlen_p, viol_p;

  int checks = 0;
  int errors = 0;
  logic [63:0] sbq [$];

  always #5 clk = ~clk;

  // One DUT plus one receiver model per parameter set.
  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int W = w_of(gi);
    localparam int H = h_of(gi);

    logic [W-1:0] rx;
    logic [2:0]   s1, s2, s3;
    logic         s4_sclk;
    logic         prev_sclk, prev_sdata;
    logic [15:0]  rises, senlen, viol;

    config_serial_tx #(.WIDTH(W), .HALF_PERIOD(H)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start_v[gi]),
      .data  (data_a[gi][W-1:0]),
      .busy  (busy_v[gi]),
      .done  (done_v[gi]),
      .sen   (sen_v[gi]),
      .sclk  (sclk_v[gi]),
      .sdata (sdata_v[gi])
    );

    // Receiver model and link monitors, sampled on the inactive edge.
    always @(negedge clk) begin
      s1      <= {sen_v[gi], sclk_v[gi], sdata_v[gi]};
      s2      <= s1;
      s3      <= s2;
      s4_sclk <= s3[1];
      if (s3[2] && s3[1] && !s4_sclk) rx <= {s3[0], rx[W-1:1]};
      prev_sclk  <= sclk_v[gi];
      prev_sdata <= sdata_v[gi];
      if (mon_clr[gi]) begin
        rises  <= '0;
        senlen <= '0;
        viol   <= '0;
      end else begin
        if (sclk_v[gi] && !prev_sclk) rises <= rises + 16'd1;
        if (sen_v[gi]) senlen <= senlen + 16'd1;
        if (sclk_v[gi] && (sdata_v[gi] != prev_sdata)) viol <= viol + 16'd1;
      end
    end

    assign rx_p[gi]     = 64'(rx);
    assign rises_p[gi]  = rises;
    assign senlen_p[gi] = senlen;
    assign viol_p[gi]   = viol;
  end

  // Sends one frame on instance k, starting at the next falling edge (cycle 0).
  // Checks the timing landmarks, then pops the expected word and compares it.
  task automatic run_frame(input int k, input logic [63:0] d_in, input string name,
                           output int first_hi, output int hi_cnt);
    int w, h, cyc, done_cyc, idle_cyc, lim;
    logic [63:0] d, exp_w;
    w = w_of(k);
    h = h_of(k);
    d = d_in & ((64'd1 << w) - 64'd1);
    lim = (2 * w + 2) * h + 50;
    first_hi = -1;
    hi_cnt   = 0;
    done_cyc = -1;
    idle_cyc = -1;
    mon_clr[k] <= 1'b1;
    @(negedge clk);
    mon_clr[k] <= 1'b0;
    start_v[k] = 1'b1;
    data_a[k]  = d;
    sbq.push_back(d);
    @(negedge clk);
    cyc = 1;
    start_v[k] = 1'b0;
    data_a[k]  = ~d;
    checks++;
    if ({busy_v[k], sen_v[k], sclk_v[k], sdata_v[k]} !== {3'b110, d[0]}) begin
      errors++;
      $display("FAIL %s first_cycle: busy/sen/sclk/sdata got %b expected %b",
               name, {busy_v[k], sen_v[k], sclk_v[k], sdata_v[k]}, {3'b110, d[0]});
    end
    while (cyc < lim && idle_cyc < 0) begin
      if (sdata_v[k] === 1'b1) begin
        if (first_hi < 0) first_hi = cyc;
        hi_cnt++;
      end
      if (done_v[k] === 1'b1 && done_cyc < 0) begin
        done_cyc = cyc;
        checks++;
        if (sen_v[k] !== 1'b0) begin
          errors++;
          $display("FAIL %s sen_at_done: got %b expected 0", name, sen_v[k]);
        end
      end
      if (busy_v[k] === 1'b0) idle_cyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (done_cyc != (2 * w + 1) * h + 1) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, (2 * w + 1) * h + 1);
    end
    checks++;
    if (idle_cyc != (2 * w + 2) * h + 1) begin
      errors++;
      $display("FAIL %s busy_low_cycle: got %0d expected %0d", name, idle_cyc, (2 * w + 2) * h + 1);
    end
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: queue empty, got rx %h", name, rx_p[k]);
    end else begin
      exp_w = sbq.pop_front();
      if (rx_p[k] !== exp_w) begin
        errors++;
        $display("FAIL %s rx_word: got %h expected %h", name, rx_p[k], exp_w);
      end
    end
    checks++;
    if (int'(rises_p[k]) != w) begin
      errors++;
      $display("FAIL %s sclk_rises: got %0d expected %0d", name, rises_p[k], w);
    end
    checks++;
    if (int'(senlen_p[k]) != (2 * w + 1) * h) begin
      errors++;
      $display("FAIL %s sen_high_len: got %0d expected %0d", name, senlen_p[k], (2 * w + 1) * h);
    end
    checks++;
    if (viol_p[k] !== 16'd0) begin
      errors++;
      $display("FAIL %s sdata_stable_high: got %0d changes expected 0", name, viol_p[k]);
    end
    $display("frame %s inst=%0d data=%h done@%0d idle@%0d rx=%h", name, k, d, done_cyc, idle_cyc, rx_p[k]);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start_v = '1;
    mon_clr = '0;
    for (int i = 0; i < NI; i++) data_a[i] = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_v !== '0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0000", busy_v);
    end
    checks++;
    if (done_v !== '0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0000", done_v);
    end
    checks++;
    if (sen_v !== '0) begin
      errors++;
      $display("FAIL reset_sen: got %b expected 0000", sen_v);
    end
    checks++;
    if (sclk_v !== '0) begin
      errors++;
      $display("FAIL reset_sclk: got %b expected 0000", sclk_v);
    end
    checks++;
    if (sdata_v !== '0) begin
      errors++;
      $display("FAIL reset_sdata: got %b expected 0000", sdata_v);
    end
    reset   = 1'b0;
    start_v = '0;
    @(negedge clk);
    $display("reset: outputs busy=%b sen=%b sclk=%b sdata=%b", busy_v, sen_v, sclk_v, sdata_v);
  endtask

  task automatic test_basic_frame();
    int fh, hc;
    run_frame(0, 64'h5_C3F0_1234_5678, "basic", fh, hc);
  endtask

  task automatic test_bit_order();
    int fh, hc;
    run_frame(0, 64'h0_0000_0000_0001, "lsb_only", fh, hc);
    checks++;
    if (fh != 1 || hc != 8) begin
      errors++;
      $display("FAIL lsb_only sdata_window: got first=%0d len=%0d expected first=1 len=8", fh, hc);
    end
    run_frame(0, 64'h8_0000_0000_0000, "msb_only", fh, hc);
    checks++;
    if (fh != 1 + 2 * 4 * 51 || hc != 8) begin
      errors++;
      $display("FAIL msb_only sdata_window: got first=%0d len=%0d expected first=%0d len=8",
               fh, hc, 1 + 2 * 4 * 51);
    end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    logic prev_busy;
    logic [63:0] d, exp_w;
    int n;
    @(negedge clk);
    prev_busy = busy_v[0];
    for (int c = 0; c < 860; c++) begin
      if (c > 0) @(negedge clk);
      if (prev_busy && !busy_v[0]) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL b2b_word: queue empty, got rx %h", rx_p[0]);
        end else begin
          exp_w = sbq.pop_front();
          if (rx_p[0] !== exp_w) begin
            errors++;
            $display("FAIL b2b_word: got %h expected %h", rx_p[0], exp_w);
          end
          $display("b2b frame end @%0d rx=%h", c, rx_p[0]);
        end
      end
      prev_busy = busy_v[0];
      d = {$urandom, $urandom} & MASK52;
      start_v[0] = 1'b1;
      data_a[0]  = d;
      if (busy_v[0] === 1'b0) begin
        sbq.push_back(d);
        acc.push_back(c);
      end
    end
    start_v[0] = 1'b0;
    n = 0;
    while (busy_v[0] !== 1'b0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_v[0] !== 1'b0 || sbq.size() == 0) begin
      errors++;
      $display("FAIL b2b_last_word: busy=%b queue=%0d expected idle with one word", busy_v[0], sbq.size());
    end else begin
      exp_w = sbq.pop_front();
      if (rx_p[0] !== exp_w) begin
        errors++;
        $display("FAIL b2b_last_word: got %h expected %h", rx_p[0], exp_w);
      end
    end
    checks++;
    if (acc.size() != 3) begin
      errors++;
      $display("FAIL b2b_accept_count: got %0d expected 3", acc.size());
    end else if (acc[0] != 0 || acc[1] != 425 || acc[2] != 850) begin
      errors++;
      $display("FAIL b2b_accept_cycles: got %0d,%0d,%0d expected 0,425,850", acc[0], acc[1], acc[2]);
    end
    $display("b2b: %0d accepts", acc.size());
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] d;
    logic saw_done;
    int fh, hc;
    d = 64'hA_5A5A_0F0F_C3C3;
    saw_done = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b1;
    data_a[0]  = d;
    sbq.push_back(d);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (done_v[0] === 1'b1) saw_done = 1'b1;
    end
    reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy_v[0], done_v[0], sen_v[0], sclk_v[0], sdata_v[0]} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_outputs: busy/done/sen/sclk/sdata got %b expected 00000",
               {busy_v[0], done_v[0], sen_v[0], sclk_v[0], sdata_v[0]});
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midreset_done: got done pulse expected none");
    end
    $display("midreset: outputs cleared at cycle 201");
    run_frame(0, 64'h3_1415_9265_3589, "after_reset", fh, hc);
  endtask

  task automatic test_param_sweep();
    int fh, hc;
    for (int k = 1; k < NI; k++) begin
      run_frame(k, {$urandom, $urandom}, "sweep", fh, hc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bit_order();
    test_back_to_back();
    test_reset_mid_frame();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
